// File: rtl/pacote_processador.sv
// Definitions shared by the instruction-fetch sequencer and its PC datapath.
// The opcode values must stay in step with SinalDeControle.
package pacote_processador;

    typedef enum logic [2:0] {
        FETCH      = 3'd0,
        DECODE     = 3'd1,
        EXEC       = 3'd2,
        ESPERA_MEM = 3'd3,
        PARADO     = 3'd4
    } estado_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2,
        PC_REL  = 2'd3
    } pc_sel_t;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RS_MSB  = 11;
    localparam int RS_LSB  = 8;
    localparam int RT_MSB  = 7;
    localparam int RT_LSB  = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_J    = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/contador_programa.sv
// Program counter: hold, increment, absolute load or PC-relative branch.
// All arithmetic wraps modulo 2^PC_WIDTH.
module contador_programa
    import pacote_processador::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  pc_sel_t             sel,
    input  logic [PC_WIDTH-1:0] alvo,
    input  logic [3:0]          desloc,
    output logic [PC_WIDTH-1:0] pc
);

    localparam logic [PC_WIDTH-1:0] UM = PC_WIDTH'(1);

    logic [PC_WIDTH-1:0] desloc_ext;

    assign desloc_ext = PC_WIDTH'($signed(desloc));

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            case (sel)
                PC_HOLD: pc <= pc;
                PC_INC:  pc <= pc + UM;
                PC_LOAD: pc <= alvo;
                PC_REL:  pc <= pc + UM + desloc_ext;
            endcase
        end
    end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch/sequencer: fetches over req/ack, holds IR, drives the
// control decoder and steps PC through FETCH/DECODE/EXEC until Halt.
//
// state      | meaning
// FETCH      | imem_req high, waiting for imem_ack to load IR
// DECODE     | one cycle so the clocked decoder can register its outputs
// EXEC       | decoder outputs sampled, PC updated, instr_valid high
// ESPERA_MEM | waiting for dmem_done after a load/store
// PARADO     | halted; only reset leaves this state
module busca_instrucao
    import pacote_processador::*;
#(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [3:0]             OpCode,
    output logic [3:0]             campo_rs,
    output logic [3:0]             campo_rt,
    output logic [3:0]             campo_imm,
    input  logic                   Halt,
    input  logic                   Salto,
    input  logic                   Beq,
    input  logic                   LerMem,
    input  logic                   EscMem,
    input  logic                   zero,
    input  logic                   dmem_done,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   instr_valid,
    output logic                   halted
);

    estado_t                estado;
    logic [INSTR_WIDTH-1:0] ir;
    pc_sel_t                pc_sel;

    assign OpCode    = ir[OP_MSB:OP_LSB];
    assign campo_rs  = ir[RS_MSB:RS_LSB];
    assign campo_rt  = ir[RT_MSB:RT_LSB];
    assign campo_imm = ir[IMM_MSB:IMM_LSB];
    assign imem_addr = pc;

    always_comb begin
        pc_sel = PC_HOLD;
        if (estado == EXEC && !Halt) begin
            if (Salto)
                pc_sel = PC_LOAD;
            else if (Beq && zero)
                pc_sel = PC_REL;
            else
                pc_sel = PC_INC;
        end
    end

    contador_programa #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_contador_programa (
        .clock  (clock),
        .reset  (reset),
        .sel    (pc_sel),
        .alvo   (PC_WIDTH'(ir[RT_MSB:IMM_LSB])),
        .desloc (ir[IMM_MSB:IMM_LSB]),
        .pc     (pc)
    );

    // imem_req is registered, so every transition into FETCH raises it directly;
    // an ack is only accepted while the request is actually on the bus.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado      <= FETCH;
            ir          <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            case (estado)
                FETCH: begin
                    if (imem_req && imem_ack) begin
                        ir       <= imem_data;
                        imem_req <= 1'b0;
                        estado   <= DECODE;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                DECODE: begin
                    instr_valid <= 1'b1;
                    estado      <= EXEC;
                end
                EXEC: begin
                    if (Halt) begin
                        halted <= 1'b1;
                        estado <= PARADO;
                    end else if (LerMem || EscMem) begin
                        estado <= ESPERA_MEM;
                    end else begin
                        imem_req <= 1'b1;
                        estado   <= FETCH;
                    end
                end
                ESPERA_MEM: begin
                    if (dmem_done) begin
                        imem_req <= 1'b1;
                        estado   <= FETCH;
                    end
                end
                PARADO: begin
                    imem_req <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    imem_req <= 1'b0;
                    estado   <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
Instruction fetch/sequencer. It is the issuing end of the control-decoder interface: it drives OpCode into SinalDeControle and consumes the returned Halt, Salto, Beq, LerMem and EscMem.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Holds the instruction register (IR) and program counter (PC).
- Sequences a multi-cycle FETCH/DECODE/EXEC flow until Halt.

Parameters:
PC_WIDTH, 8, program counter and instruction-address width
INSTR_WIDTH, 16, instruction word width; OpCode is always IR[15:12]
RESET_PC, 0, PC value loaded on reset

Ports:
clock  in  1  single system clock, rising edge
reset  in  1  synchronous, active-low reset
imem_req  out  1  instruction-read request
imem_addr  out  PC_WIDTH  instruction address (= PC)
imem_ack  in  1  read data valid this cycle
imem_data  in  INSTR_WIDTH  instruction word
OpCode  out  4  to control decoder; IR[15:12]
campo_rs  out  4  IR[11:8]
campo_rt  out  4  IR[7:4]
campo_imm  out  4  IR[3:0]
Halt  in  1  from decoder
Salto  in  1  from decoder: unconditional jump
Beq  in  1  from decoder: branch if equal
LerMem  in  1  from decoder: data-memory read
EscMem  in  1  from decoder: data-memory write
zero  in  1  ULA zero flag, valid in EXEC
dmem_done  in  1  data-memory access complete
pc  out  PC_WIDTH  current PC
instr_valid  out  1  one-cycle pulse on entering EXEC
halted  out  1  processor halted

Behaviour:
- Reset (reset==0 at a clock edge): PC=RESET_PC, IR=0, state=FETCH.
  - All outputs 0 except imem_addr=pc=RESET_PC.
  - Reset dominates any other event in the same cycle, including mid-handshake. A pending imem_ack during reset is ignored.
- States: FETCH, DECODE, EXEC, ESPERA_MEM, PARADO.
- FETCH:
  - imem_req=1; imem_addr=PC, held stable until ack.
  - On imem_ack: IR<=imem_data, go to DECODE. imem_req drops the cycle after ack.
  - Ack may arrive in the first request cycle (minimum 1 cycle in FETCH). No timeout.
- DECODE:
  - One cycle. OpCode already reflects the new IR.
  - This gives the clocked decoder one edge to register its outputs.
  - Go to EXEC.
- EXEC:
  - One cycle; instr_valid=1; samples Halt, Salto, Beq, zero, LerMem, EscMem.
  - Priority: Halt > Salto > (Beq&&zero) > sequential.
  - Halt: PC unchanged, go to PARADO.
  - Salto: PC<=IR[7:0] (zero-extended/truncated to PC_WIDTH).
  - Beq&&zero: PC<=PC+1+sext(IR[3:0]).
  - Beq with zero=0, or any other opcode: PC<=PC+1.
  - All PC arithmetic is modulo 2^PC_WIDTH. Wrap-around is legal: 0xFF+1=0x00; 0x00+1+(-2)=0xFF.
  - If (LerMem|EscMem) and not Halt: go to ESPERA_MEM, otherwise go to FETCH.
  - If Salto and LerMem are both set, the PC update is applied and the memory wait still occurs.
- ESPERA_MEM:
  - PC already updated; wait for dmem_done, then go to FETCH.
  - dmem_done outside ESPERA_MEM is ignored.
- PARADO:
  - halted=1, imem_req=0; PC and IR frozen.
  - Only reset exits this state.
- OpCode/campo_* are combinational from IR and stable from DECODE through the next FETCH ack.
- Throughput with zero-wait memory: 3 cycles per instruction, plus dmem wait cycles.

Decomposition:
- Shared package (pacote_processador):
  - State encoding constants.
  - Opcode field positions (15:12, 11:8, 7:4, 3:0).
  - Opcode constants matching SinalDeControle, including the HALT opcode.
- Sub-module: contador_programa.
  - PC register with reset, hold, increment, absolute load and relative branch.
  - Select inputs are driven by the sequencer FSM.

Test Plan:
- Reset then zero-wait memory returning 0x1000 (non-branch) every fetch -> imem_addr 0,1,2 at cycles 1,4,7; instr_valid every 3rd cycle; OpCode=0001.
- Fetch with ack delayed 4 cycles -> imem_req held high 5 cycles with imem_addr stable; IR loaded only on the ack cycle.
- Jump: PC=5, IR=0x?0A7, Salto=1 in EXEC -> next imem_addr=0xA7. Branch: PC=0x10, IR[3:0]=0xE, Beq=1, zero=1 -> next PC=0x0F. Same with zero=0 -> 0x11.
- LerMem=1 in EXEC, dmem_done after 3 cycles -> no imem_req for 3 cycles, then fetch from PC+1. A dmem_done pulse during FETCH is ignored.
- Halt=1 together with Salto=1 -> halted=1, PC unchanged, imem_req stays 0 for 20 cycles. Reset low then high -> fetch resumes at RESET_PC.
- PC=0xFF sequential -> next imem_addr=0x00. Reset asserted mid-FETCH with ack in the same cycle -> IR=0, PC=RESET_PC, state FETCH.
